t07_esp32_spi_rx: RTL and testbench

- SPI slave receiver that takes the serial link from the ESP32 co-processor and assembles 32-bit words for the MMIO block.
- Drives the MMIO's ESP32 data word (SPIData_i) and its full-word strobe (SPIack_i). The MMIO latches the word on that strobe and serves it to CPU loads in the 1025–1056 address window.
- Upstream pins are asynchronous to clk. All sampling is oversampled through synchronizers; no logic runs on the SPI clock.

---
 rtl/t07_esp32_pkg.sv | 16 +
 rtl/t07_esp32_spi_rx_if.sv | 37 +++
 rtl/t07_sync_edge.sv | 33 +++
 rtl/t07_esp32_spi_rx.sv | 109 ++++++++++
 tb/tb_t07_esp32_spi_rx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/t07_esp32_pkg.sv
// Shared types and constants for the ESP32 SPI receive path.
// Holds the FSM state type, default word width and MMIO window bounds.
package t07_esp32_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WORD_BITS_DEF = 32;

    // CPU load window in which the MMIO serves the received word.
    localparam int ESP_REG_LO = 1025;
    localparam int ESP_REG_HI = 1056;

endpackage

// File: rtl/t07_esp32_spi_rx_if.sv
// ESP32 SPI link plus the word/strobe bundle handed to the MMIO.
// slave: receiver side (pins in, word/ack/err/busy out); master: the ESP32/MMIO side.
interface t07_esp32_spi_rx_if
    import t07_esp32_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEF
) ();

    logic                 esp_sclk_i;
    logic                 esp_cs_n_i;
    logic                 esp_mosi_i;
    logic [WORD_BITS-1:0] SPIData_o;
    logic                 SPIack_o;
    logic                 frame_err_o;
    logic                 busy_o;

    modport slave (
        input  esp_sclk_i,
        input  esp_cs_n_i,
        input  esp_mosi_i,
        output SPIData_o,
        output SPIack_o,
        output frame_err_o,
        output busy_o
    );

    modport master (
        output esp_sclk_i,
        output esp_cs_n_i,
        output esp_mosi_i,
        input  SPIData_o,
        input  SPIack_o,
        input  frame_err_o,
        input  busy_o
    );

endinterface

// File: rtl/t07_sync_edge.sv
// STAGES-deep synchronizer with one extra delay flop and rise/fall detect.
// Ports: clk, rst, din (async pin) -> q (synced), dly (q one clk later), rise, fall.
module t07_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic dly,
    output logic rise,
    output logic fall
);

    // STAGES must be at least 2.
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= {STAGES{RST_VAL}};
            dly <= RST_VAL;
        end else begin
            sr  <= {sr[STAGES-2:0], din};
            dly <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = q & ~dly;
    assign fall = ~q & dly;

endmodule

// File: rtl/t07_esp32_spi_rx.sv
// Oversampled mode-0 SPI slave that assembles MSB-first words for the MMIO.
// Ports: clk, rst, bus (slave: sclk/cs_n/mosi in; SPIData/SPIack/frame_err/busy out).
module t07_esp32_spi_rx
    import t07_esp32_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = WORD_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    t07_esp32_spi_rx_if.slave      bus
);

    localparam int CW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    logic sclk_q, sclk_d, sclk_rise, sclk_fall;
    logic cs_q, cs_d, cs_rise, cs_fall;
    logic mosi_q, mosi_d, mosi_rise, mosi_fall;

    t07_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(bus.esp_sclk_i),
        .q(sclk_q), .dly(sclk_d), .rise(sclk_rise), .fall(sclk_fall)
    );

    t07_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(bus.esp_cs_n_i),
        .q(cs_q), .dly(cs_d), .rise(cs_rise), .fall(cs_fall)
    );

    // The delayed copy lines mosi up with the cycle sclk_rise is seen.
    t07_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(bus.esp_mosi_i),
        .q(mosi_q), .dly(mosi_d), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_q, sclk_d, sclk_fall, cs_q, cs_d,
                           mosi_q, mosi_rise, mosi_fall};

    state_t               state;
    logic [CW-1:0]        bitcnt;
    logic [WORD_BITS-1:0] shreg;
    logic [WORD_BITS-1:0] data;
    logic                 done;
    logic                 ack;
    logic                 err;
    logic                 busy;

    logic [WORD_BITS-1:0] shifted;
    logic [CW-1:0]        cnt_nx;
    logic [CW-1:0]        cnt_post;
    logic                 at_last;

    assign shifted  = {shreg[WORD_BITS-2:0], mosi_d};
    assign at_last  = (bitcnt == LAST);
    assign cnt_nx   = at_last ? '0 : bitcnt + 1'b1;
    // CS is judged against the count after any same-cycle shift.
    assign cnt_post = sclk_rise ? cnt_nx : bitcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            data   <= '0;
            done   <= 1'b0;
            ack    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Word lands one cycle ahead of its strobe.
            ack  <= done;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                        shreg  <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shreg  <= shifted;
                        bitcnt <= cnt_nx;
                        if (at_last) begin
                            data <= shifted;
                            done <= 1'b1;
                        end
                    end
                    if (cs_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= (cnt_post != '0);
                    end
                end
            endcase
        end
    end

    assign bus.SPIData_o   = data;
    assign bus.SPIack_o    = ack;
    assign bus.frame_err_o = err;
    assign bus.busy_o      = busy;

endmodule

// File: tb/tb_t07_esp32_spi_rx.sv
// Bench for the ESP32 SPI receiver against a word/frame level model.
// Drives SPI pins through the interface; checks word, ack timing, errors, busy.
module tb_t07_esp32_spi_rx;
    import t07_esp32_pkg::*;

    localparam int WB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    t07_esp32_spi_rx_if #(.WORD_BITS(WB)) bus ();

    t07_esp32_spi_rx #(.SYNC_STAGES(2), .WORD_BITS(WB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: bits collected per frame, words and their
    // final-SCLK-rise times queued for the ack monitor.
    int          nbits = 0;
    logic [31:0] acc = '0;
    logic [31:0] wq[$];
    int          tq[$];
    int          exp_err = 0;
    int          err_seen = 0;
    bit          fq[$];

    task automatic model_bit(input bit b);
        acc = {acc[30:0], b};
        nbits++;
        if (nbits == WB) begin
            wq.push_back(acc);
            tq.push_back(cyc);
            nbits = 0;
        end
    endtask

    task automatic model_cs_rise();
        if (nbits != 0) exp_err++;
        nbits = 0;
    endtask

    // Monitor, sampled mid-cycle.
    logic [31:0] last_data;
    logic        prev_ack = 1'b0;
    logic        prev_err = 1'b0;
    bit          chg_pending = 0;

    always @(negedge clk) begin
        logic [31:0] w;
        int t;
        if (!rst_q) begin
            if (chg_pending) begin
                check("data_then_ack", bus.SPIack_o, 1'b1);
                chg_pending = 0;
            end
            if (bus.SPIData_o !== last_data) chg_pending = 1;
            if (bus.SPIack_o) begin
                check("ack_width", prev_ack, 1'b0);
                check("ack_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    t = tq.pop_front();
                    check("word", bus.SPIData_o, w);
                    check("ack_latency", 32'(cyc - t), 32'd4);
                end
            end
            if (bus.frame_err_o) begin
                check("err_width", prev_err, 1'b0);
                err_seen++;
            end
        end else begin
            chg_pending = 0;
        end
        last_data = bus.SPIData_o;
        prev_ack  = bus.SPIack_o;
        prev_err  = bus.frame_err_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) fq.push_back(w[i]);
    endtask

    task automatic send_bit(input bit b, input int half);
        bus.esp_mosi_i = b;
        tick(half);
        bus.esp_sclk_i = 1'b1;
        model_bit(b);
        tick(half);
        bus.esp_sclk_i = 1'b0;
    endtask

    task automatic open_frame();
        bus.esp_cs_n_i = 1'b0;
        tick(4);
        check("busy_open", bus.busy_o, 1'b1);
    endtask

    // Sends fq; with coinc the last SCLK rise and CS rise share a clk.
    task automatic send_frame(input int half, input bit coinc);
        int n;
        bit b;
        open_frame();
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            b = fq.pop_front();
            if (coinc && i == n - 1) begin
                bus.esp_mosi_i = b;
                tick(half);
                bus.esp_sclk_i = 1'b1;
                bus.esp_cs_n_i = 1'b1;
                model_bit(b);
                model_cs_rise();
                tick(half);
                bus.esp_sclk_i = 1'b0;
            end else begin
                send_bit(b, half);
            end
        end
        if (!(coinc && n > 0)) begin
            tick(half);
            bus.esp_cs_n_i = 1'b1;
            model_cs_rise();
        end
        tick(8);
        check("busy_closed", bus.busy_o, 1'b0);
        check("acks_drained", wq.size(), 0);
        check("err_count", err_seen, exp_err);
    endtask

    task automatic reset_model();
        nbits = 0;
        wq.delete();
        tq.delete();
    endtask

    initial begin
        int nw, ex, half;
        bit coinc;
        bus.esp_sclk_i = 1'b0;
        bus.esp_cs_n_i = 1'b1;
        bus.esp_mosi_i = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_data", bus.SPIData_o, 32'd0);
        check("rst_ack", bus.SPIack_o, 1'b0);
        check("rst_err", bus.frame_err_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        tick(4);

        // Single word at SCLK = clk/8.
        add_bits(32'hDEADBEEF, 32);
        send_frame(4, 0);
        check("single_word", bus.SPIData_o, 32'hDEADBEEF);

        // Two words in one frame.
        add_bits(32'h12345678, 32);
        add_bits(32'hA5A5A5A5, 32);
        send_frame(4, 0);
        check("b2b_last", bus.SPIData_o, 32'hA5A5A5A5);

        // Abort after 20 bits.
        add_bits(32'hFFFFFFFF, 32);
        send_frame(3, 0);
        add_bits(32'h000ABCDE, 20);
        send_frame(4, 0);
        check("abort_hold", bus.SPIData_o, 32'hFFFFFFFF);
        check("abort_err", err_seen, 1);

        // Reset after 10 bits of a frame.
        add_bits(32'h3FF, 10);
        open_frame();
        for (int i = 0; i < 10; i++) send_bit(fq.pop_front(), 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        reset_model();
        check("midrst_data", bus.SPIData_o, 32'd0);
        tick(4);
        bus.esp_cs_n_i = 1'b1;
        model_cs_rise();
        tick(8);
        add_bits(32'h00000001, 32);
        send_frame(4, 0);
        check("midrst_word", bus.SPIData_o, 32'h00000001);
        check("midrst_err", err_seen, 1);

        // Final bit and CS release together.
        add_bits(32'hC0FFEE11, 32);
        send_frame(4, 1);
        check("coinc_word", bus.SPIData_o, 32'hC0FFEE11);
        check("coinc_err", err_seen, 1);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            nw = $urandom_range(0, 2);
            ex = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 0;
            half = $urandom_range(3, 5);
            coinc = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < nw; k++) add_bits($urandom, 32);
            if (ex > 0) add_bits($urandom, ex);
            send_frame(half, coinc);
        end

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
